// File: rtl/abc_diff_rx_pkg.sv
// abc_diff_rx shared definitions: default parameters, byte width, FSM states
// and the signed-overflow helper for the byte difference.
package abc_pkg;

   localparam int unsigned THRESH_DEF = 9;
   localparam int unsigned CNT_W_DEF  = 5;
   localparam int unsigned BYTE_W     = 8;

   typedef enum logic [1:0] {
      IDLE,
      SPACE,
      EMIT
   } state_t;

   // a - b overflowed when the operands differ in sign and the result's sign
   // does not follow the minuend.
   function automatic logic sub_overflow(input logic [BYTE_W-1:0] a,
                                         input logic [BYTE_W-1:0] b,
                                         input logic [BYTE_W-1:0] d);
      return (a[BYTE_W-1] != b[BYTE_W-1]) && (a[BYTE_W-1] != d[BYTE_W-1]);
   endfunction

endpackage

// File: rtl/abc_diff_rx_if.sv
// abc_diff_rx line/consumer bundle: serial input plus difference outputs.
// master = line driver / byte consumer, slave = the receiver.
interface abc_diff_rx_if;
   import abc_pkg::*;

   logic              rxd;
   logic [BYTE_W-1:0] out;
   logic              signal;
   logic              ow;

   modport master (
      output rxd,
      input  out,
      input  signal,
      input  ow
   );

   modport slave (
      input  rxd,
      output out,
      output signal,
      output ow
   );

endinterface

// File: rtl/abc_diff_rx_pulse_decoder.sv
// abc_pulse_decoder: measures each space (rxd = 0) run and, on the first mark
// cycle after it, reports the decoded bit (long pulse = 1).
// Optional macro ABC_GLITCH_FILTER_EN: a space run of exactly one cycle
// produces no bit at all.
module abc_pulse_decoder
   import abc_pkg::*;
#(
   parameter int unsigned THRESH = THRESH_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic clock,
   input  logic reset_,
   input  logic rxd,
   output logic bit_valid,
   output logic bit_val
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Nonzero count means "inside a space run"; it clears on the first mark.
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Space-length counter, saturating so overlong pulses still read as 1.
   always_comb begin
      cnt_d = cnt_q;
      if (rxd) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clock) begin
      if (!reset_) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

`ifdef ABC_GLITCH_FILTER_EN
   assign bit_valid = rxd && (cnt_q != '0) && (cnt_q != CNT_W'(1));
`else
   assign bit_valid = rxd && (cnt_q != '0);
`endif

   assign bit_val = (cnt_q >= CNT_W'(THRESH));

endmodule

// File: rtl/abc_diff_rx.sv
// abc_diff_rx: pulse-width serial receiver that assembles bytes LSB first and
// emits current - previous byte, or an overflow strobe instead of a result.
// Glitch suppression (ABC_GLITCH_FILTER_EN) lives in abc_pulse_decoder.
module abc_diff_rx
   import abc_pkg::*;
#(
   parameter int unsigned THRESH = THRESH_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic          clock,
   input  logic          reset_,
   abc_diff_rx_if.slave  bus
);

   localparam int unsigned IDX_W = $clog2(BYTE_W);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [BYTE_W-1:0] shift_q, shift_d;
   logic [BYTE_W-1:0] prev_q, prev_d;
   logic [BYTE_W-1:0] out_q, out_d;
   logic              signal_q, signal_d;
   logic              ow_q, ow_d;

   logic              bit_valid;
   logic              bit_val;
   logic [BYTE_W-1:0] diff;
   logic              ovf;

   abc_pulse_decoder #(
      .THRESH (THRESH),
      .CNT_W  (CNT_W)
   ) u_dec (
      .clock     (clock),
      .reset_    (reset_),
      .rxd       (bus.rxd),
      .bit_valid (bit_valid),
      .bit_val   (bit_val)
   );

   assign diff = shift_q - prev_q;
   assign ovf  = sub_overflow(shift_q, prev_q, diff);

   // Next state: bit capture in SPACE, difference/overflow decision in EMIT.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      prev_d   = prev_q;
      out_d    = out_q;
      signal_d = 1'b0;
      ow_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!bus.rxd) begin
               state_d = SPACE;
            end
         end
         SPACE: begin
            if (bus.rxd) begin
               state_d = IDLE;
               if (bit_valid) begin
                  shift_d[idx_q] = bit_val;
                  idx_d          = idx_q + IDX_W'(1);
                  if (idx_q == IDX_W'(BYTE_W - 1)) begin
                     state_d = EMIT;
                  end
               end
            end
         end
         EMIT: begin
            if (ovf) begin
               ow_d   = 1'b1;
               prev_d = '0;
            end else begin
               out_d    = diff;
               signal_d = 1'b1;
               prev_d   = shift_q;
            end
            idx_d   = '0;
            // A space starting in this cycle is counted by the decoder already.
            state_d = bus.rxd ? IDLE : SPACE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clock) begin
      if (!reset_) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         shift_q  <= '0;
         prev_q   <= '0;
         out_q    <= '0;
         signal_q <= 1'b0;
         ow_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         prev_q   <= prev_d;
         out_q    <= out_d;
         signal_q <= signal_d;
         ow_q     <= ow_d;
      end
   end

   assign bus.out    = out_q;
   assign bus.signal = signal_q;
   assign bus.ow     = ow_q;

endmodule

// File: tb/tb_abc_diff_rx.sv
// Directed + randomized bench for abc_diff_rx. The reference model decodes
// each sent pulse into a bit queue and computes byte differences with signed
// integer arithmetic.
module tb_abc_diff_rx;

   localparam int TH = 9;
`ifdef ABC_GLITCH_FILTER_EN
   localparam bit GLITCH = 1'b1;
`else
   localparam bit GLITCH = 1'b0;
`endif

   logic clock;
   logic reset_;

   abc_diff_rx_if bus ();

   abc_diff_rx #(
      .THRESH (9),
      .CNT_W  (5)
   ) dut (
      .clock  (clock),
      .reset_ (reset_),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit bq[$];
   int prev_m  = 0;
   int exp_out = 0;
   int exp_sig = 0;
   int exp_ow  = 0;

   // strobe / hold monitor
   int         sig_cnt     = 0;
   int         ow_cnt      = 0;
   int         both_cnt    = 0;
   int         hold_err    = 0;
   logic [7:0] last_out;
   logic       rst_prev_low = 1'b1;

   always @(negedge clock) begin
      if (bus.signal === 1'b1) sig_cnt <= sig_cnt + 1;
      if (bus.ow === 1'b1) ow_cnt <= ow_cnt + 1;
      if (bus.signal === 1'b1 && bus.ow === 1'b1) both_cnt <= both_cnt + 1;
      if (!rst_prev_low && reset_ && bus.signal !== 1'b1 && bus.out !== last_out)
         hold_err <= hold_err + 1;
      last_out     <= bus.out;
      rst_prev_low <= !reset_;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input int cycles);
      reset_ = 1'b0;
      repeat (cycles) begin
         @(posedge clock);
         #1;
      end
      reset_ = 1'b1;
      bq.delete();
      prev_m  = 0;
      exp_out = 0;
   endtask

   // Send one space pulse of len cycles then mark cycles of idle line.
   task automatic pulse(input int len, input int mark);
      bit done, es, eo;
      int cur, cs, ps, sd;
      done = 1'b0;
      es   = 1'b0;
      eo   = 1'b0;
      if (!(GLITCH && len == 1)) begin
         bq.push_back(len >= TH);
         if (bq.size() == 8) begin
            cur = 0;
            foreach (bq[i]) if (bq[i]) cur += (1 << i);
            bq.delete();
            cs = (cur > 127) ? cur - 256 : cur;
            ps = (prev_m > 127) ? prev_m - 256 : prev_m;
            sd = cs - ps;
            if (sd < -128 || sd > 127) begin
               eo     = 1'b1;
               exp_ow++;
               prev_m = 0;
            end else begin
               es      = 1'b1;
               exp_sig++;
               exp_out = (cur - prev_m) & 255;
               prev_m  = cur;
            end
            done = 1'b1;
         end
      end
      bus.rxd = 1'b0;
      repeat (len) begin
         @(posedge clock);
         #1;
      end
      bus.rxd = 1'b1;
      for (int m = 0; m < mark; m++) begin
         @(posedge clock);
         #1;
         if (done && m == 0) begin
            check("emit_cycle_signal", bus.signal, 1'b0);
            check("emit_cycle_ow", bus.ow, 1'b0);
         end
         if (done && m == 1) begin
            check("strobe_signal", bus.signal, es);
            check("strobe_ow", bus.ow, eo);
            check("strobe_out", bus.out, exp_out);
         end
         if (done && m == 2) begin
            check("strobe_end_signal", bus.signal, 1'b0);
            check("strobe_end_ow", bus.ow, 1'b0);
         end
      end
   endtask

   // zlen/olen <= 0 selects a random nominal length for that bit value.
   task automatic send_byte(input logic [7:0] b, input int zlen, input int olen, input int mark);
      int len;
      for (int i = 0; i < 8; i++) begin
         if (b[i])
            len = (olen > 0) ? olen : int'($urandom_range(15, 11));
         else
            len = (zlen > 0) ? zlen : int'($urandom_range(7, 2));
         pulse(len, mark);
      end
   endtask

   initial begin
      logic [7:0] rb;
      bus.rxd = 1'b1;
      reset_  = 1'b0;

      // reset state
      do_reset(3);
      check("reset_out", bus.out, 8'h00);
      check("reset_signal", bus.signal, 1'b0);
      check("reset_ow", bus.ow, 1'b0);
      repeat (3) @(posedge clock);
      #1;

      // first byte against prev = 0, then an overflowing byte
      send_byte(8'h72, 0, 0, 20);
      send_byte(8'h85, 0, 0, 20);
      check("ovf_out_held", bus.out, 8'h72);
      check("ovf_count", ow_cnt, exp_ow);

      // prev cleared by overflow, then identical byte gives zero
      send_byte(8'h98, 0, 0, 20);
      send_byte(8'h98, 0, 0, 20);
      check("same_byte_out", bus.out, 8'h00);

      // threshold boundary and counter saturation
      send_byte(8'h0F, 8, 9, 20);
      send_byte(8'hF0, 7, 15, 20);
      send_byte(8'hA5, 3, 40, 20);

      // reset in the middle of a byte
      pulse(12, 5);
      pulse(3, 5);
      pulse(12, 5);
      do_reset(1);
      check("midreset_out", bus.out, 8'h00);
      check("midreset_signal", bus.signal, 1'b0);
      send_byte(8'h10, 0, 0, 20);
      check("midreset_byte_out", bus.out, 8'h10);
      check("midreset_sig_count", sig_cnt, exp_sig);

      // one-cycle glitches around byte 0x55
      pulse(1, 20);
      pulse(12, 20); pulse(4, 20); pulse(12, 20); pulse(4, 20);
      pulse(1, 20);
      pulse(12, 20); pulse(4, 20); pulse(12, 20); pulse(4, 20);
      check("glitch_out", bus.out, exp_out);
      do_reset(1);
      repeat (2) @(posedge clock);
      #1;

      // randomized bytes, lengths around the threshold, short marks
      for (int k = 0; k < 8; k++) begin
         rb = 8'($urandom);
         for (int i = 0; i < 8; i++)
            pulse(rb[i] ? int'($urandom_range(20, 9)) : int'($urandom_range(8, 2)),
                  int'($urandom_range(6, 1)));
      end
      repeat (4) @(posedge clock);
      #1;

      check("final_out", bus.out, exp_out);
      check("final_sig_count", sig_cnt, exp_sig);
      check("final_ow_count", ow_cnt, exp_ow);
      check("strobes_exclusive", both_cnt, 0);
      check("out_hold", hold_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
